// File: rtl/pc_ctrl_if.sv
// Bundles the ID/EX/MEM hazard inputs and the PC/pipeline-register controls of pc_ctrl.
// slave = pc_ctrl side, master = the side driving decode/pipeline state.
interface pc_ctrl_if #(
    parameter int RB = 5,
    parameter int CW = 32
);
    logic          imem_ready;
    logic          id_jump;
    logic          id_branch;
    logic          id_jr;
    logic          id_eq;
    logic [RB-1:0] id_rs;
    logic [RB-1:0] id_rt;
    logic          id_uses_rt;
    logic          ex_mem_read;
    logic          ex_reg_write;
    logic [RB-1:0] ex_dst;
    logic          mem_mem_read;
    logic [RB-1:0] mem_dst;

    logic          pc_write;
    logic [1:0]    pc_src;
    logic          if_id_write;
    logic          if_id_flush;
    logic          id_ex_bubble;
    logic [CW-1:0] perf_stalls;
    logic [CW-1:0] perf_flushes;

    modport slave (
        input  imem_ready, id_jump, id_branch, id_jr, id_eq, id_rs, id_rt, id_uses_rt,
        input  ex_mem_read, ex_reg_write, ex_dst, mem_mem_read, mem_dst,
        output pc_write, pc_src, if_id_write, if_id_flush, id_ex_bubble,
        output perf_stalls, perf_flushes
    );

    modport master (
        output imem_ready, id_jump, id_branch, id_jr, id_eq, id_rs, id_rt, id_uses_rt,
        output ex_mem_read, ex_reg_write, ex_dst, mem_mem_read, mem_dst,
        input  pc_write, pc_src, if_id_write, if_id_flush, id_ex_bubble,
        input  perf_stalls, perf_flushes
    );
endinterface

// File: rtl/pc_ctrl.sv
// PC / IF-ID / ID-EX control: ID-stage redirects, load-use and branch-operand stalls, redirects held until imem is ready.
// Mealy outputs (same-cycle); optional saturating perf counters under PC_CTRL_PERF_EN.
module pc_ctrl #(
    parameter int RB = 5,
    parameter int CW = 32
) (
    input  logic        clk,
    input  logic        rst,
    pc_ctrl_if.slave    bus
);
    typedef enum logic [1:0] {RUN, STALL, REDIR_PEND} st_t;

    st_t        st, st_nxt;
    logic [1:0] cnt, cnt_nxt;
    logic [1:0] pend_src, pend_nxt;

    logic       pc_write, if_id_write, if_id_flush, id_ex_bubble;
    logic [1:0] pc_src;

    logic       ex_match, mem_match, br_act, lu, bd1, bd2;
    logic [1:0] need;
    logic       take;
    logic [1:0] src;

    // Register 0 is hardwired, so it never forms a dependency.
    assign ex_match  = (bus.ex_dst != '0) &&
                       ((bus.ex_dst == bus.id_rs) || (bus.id_branch && bus.ex_dst == bus.id_rt));
    assign mem_match = (bus.mem_dst != '0) &&
                       ((bus.mem_dst == bus.id_rs) || (bus.id_branch && bus.mem_dst == bus.id_rt));
    assign br_act    = bus.id_branch | bus.id_jr;

    assign lu  = bus.ex_mem_read && (bus.ex_dst != '0) &&
                 ((bus.ex_dst == bus.id_rs) || (bus.id_uses_rt && bus.ex_dst == bus.id_rt));
    assign bd2 = br_act && bus.ex_mem_read && ex_match;
    assign bd1 = br_act && ((bus.ex_reg_write && !bus.ex_mem_read && ex_match) ||
                            (bus.mem_mem_read && mem_match));
    assign need = bd2 ? 2'd2 : ((bd1 || lu) ? 2'd1 : 2'd0);

    assign take = bus.id_jr | bus.id_jump | (bus.id_branch & bus.id_eq);
    assign src  = bus.id_jr ? 2'b11 : (bus.id_jump ? 2'b01 : 2'b10);

    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= RUN;
            cnt      <= '0;
            pend_src <= '0;
        end else begin
            st       <= st_nxt;
            cnt      <= cnt_nxt;
            pend_src <= pend_nxt;
        end
    end

    always_comb begin
        st_nxt       = st;
        cnt_nxt      = cnt;
        pend_nxt     = pend_src;
        pc_write     = 1'b0;
        pc_src       = 2'b00;
        if_id_write  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b1;
        case (st)
            RUN: begin
                if (need != 2'd0) begin
                    // cnt counts the stall cycles still owed, including this one.
                    cnt_nxt = need - 2'd1;
                    st_nxt  = (need == 2'd1) ? RUN : STALL;
                end else if (take) begin
                    if (bus.imem_ready) begin
                        pc_write     = 1'b1;
                        pc_src       = src;
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b0;
                    end else begin
                        pend_nxt = src;
                        st_nxt   = REDIR_PEND;
                    end
                end else begin
                    pc_write     = bus.imem_ready;
                    if_id_write  = bus.imem_ready;
                    id_ex_bubble = !bus.imem_ready;
                end
            end
            STALL: begin
                if (cnt <= 2'd1) begin
                    st_nxt  = RUN;
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt - 2'd1;
                end
            end
            REDIR_PEND: begin
                // ID is frozen here; only imem_ready matters.
                if (bus.imem_ready) begin
                    pc_write     = 1'b1;
                    pc_src       = pend_src;
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b0;
                    pend_nxt     = '0;
                    st_nxt       = RUN;
                end
            end
            default: begin
                st_nxt  = RUN;
                cnt_nxt = '0;
            end
        endcase
        if (rst) begin
            pc_write     = 1'b0;
            pc_src       = 2'b00;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

    assign bus.pc_write     = pc_write;
    assign bus.pc_src       = pc_src;
    assign bus.if_id_write  = if_id_write;
    assign bus.if_id_flush  = if_id_flush;
    assign bus.id_ex_bubble = id_ex_bubble;

`ifdef PC_CTRL_PERF_EN
    logic [CW-1:0] stall_q, flush_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (id_ex_bubble && (stall_q != '1))
                stall_q <= stall_q + CW'(1);
            if (if_id_flush && (flush_q != '1))
                flush_q <= flush_q + CW'(1);
        end
    end

    assign bus.perf_stalls  = stall_q;
    assign bus.perf_flushes = flush_q;
`else
    assign bus.perf_stalls  = '0;
    assign bus.perf_flushes = '0;
`endif
endmodule

// File: tb/tb_pc_ctrl.sv
// Directed checks of pc_ctrl outputs; control vector is {pc_write, pc_src, if_id_write, if_id_flush, id_ex_bubble}.
module tb_pc_ctrl;
    localparam int RB = 5;
    localparam int CW = 32;

    localparam logic [5:0] NORMAL = 6'b1_00_1_0_0;
    localparam logic [5:0] HOLD   = 6'b0_00_0_0_1;
    localparam logic [5:0] RED_J  = 6'b1_01_0_1_0;
    localparam logic [5:0] RED_B  = 6'b1_10_0_1_0;
    localparam logic [5:0] RED_JR = 6'b1_11_0_1_0;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    pc_ctrl_if #(.RB(RB), .CW(CW)) bus ();

    pc_ctrl #(.RB(RB), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        bus.imem_ready   = 1'b1;
        bus.id_jump      = 1'b0;
        bus.id_branch    = 1'b0;
        bus.id_jr        = 1'b0;
        bus.id_eq        = 1'b0;
        bus.id_rs        = '0;
        bus.id_rt        = '0;
        bus.id_uses_rt   = 1'b0;
        bus.ex_mem_read  = 1'b0;
        bus.ex_reg_write = 1'b0;
        bus.ex_dst       = '0;
        bus.mem_mem_read = 1'b0;
        bus.mem_dst      = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [5:0] exp);
        logic [5:0] obs;
        @(negedge clk);
        obs = {bus.pc_write, bus.pc_src, bus.if_id_write, bus.if_id_flush, bus.id_ex_bubble};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_cnt(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // beq on r9 with a load of r9 in EX: two stall cycles, then the taken redirect.
    task automatic beq_load_seq(input string tag);
        idle();
        bus.id_branch = 1'b1; bus.id_eq = 1'b1; bus.id_rs = 5'd9; bus.id_rt = 5'd3;
        bus.ex_mem_read = 1'b1; bus.ex_reg_write = 1'b1; bus.ex_dst = 5'd9;
        check({tag, "_stall1"}, HOLD);
        tick();
        bus.ex_mem_read = 1'b0; bus.ex_reg_write = 1'b0; bus.ex_dst = '0;
        bus.mem_mem_read = 1'b1; bus.mem_dst = 5'd9;
        check({tag, "_stall2"}, HOLD);
        tick();
        bus.mem_mem_read = 1'b0; bus.mem_dst = '0;
        check({tag, "_redir"}, RED_B);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        idle();
        check("rst_c0", HOLD);
        tick();
        check("rst_c1", HOLD);
        tick();
        check("rst_c2", HOLD);
        tick();
        rst = 1'b0;
        check_cnt("perf_stalls_rst", bus.perf_stalls, '0);
        check("run_c0", NORMAL);
        tick();
        check("run_c1", NORMAL);
        tick();

        // Load-use on rs: exactly one stall.
        bus.ex_mem_read = 1'b1; bus.ex_reg_write = 1'b1; bus.ex_dst = 5'd8; bus.id_rs = 5'd8;
        check("lu_rs_stall", HOLD);
        tick();
        idle();
        bus.mem_mem_read = 1'b1; bus.mem_dst = 5'd8; bus.id_rs = 5'd8;
        check("lu_rs_after", NORMAL);
        tick();

        // Destination r0 never stalls.
        idle();
        bus.ex_mem_read = 1'b1; bus.ex_dst = 5'd0; bus.id_rs = 5'd0;
        check("lu_r0", NORMAL);
        tick();

        // rt hazard only when the instruction reads rt.
        idle();
        bus.ex_mem_read = 1'b1; bus.ex_dst = 5'd5; bus.id_rs = 5'd1; bus.id_rt = 5'd5; bus.id_uses_rt = 1'b1;
        check("lu_rt_stall", HOLD);
        tick();
        bus.id_uses_rt = 1'b0;
        check("lu_rt_unused", NORMAL);
        tick();

        beq_load_seq("beq_ld");
        idle();
        check("beq_ld_post", NORMAL);
        tick();

        // jr depending on an EX ALU result: one stall then redirect.
        bus.id_jr = 1'b1; bus.id_rs = 5'd4; bus.ex_reg_write = 1'b1; bus.ex_dst = 5'd4;
        check("jr_alu_stall", HOLD);
        tick();
        bus.ex_reg_write = 1'b0; bus.ex_dst = '0;
        check("jr_alu_redir", RED_JR);
        tick();

        // jr wins over jump.
        idle();
        bus.id_jr = 1'b1; bus.id_jump = 1'b1; bus.id_rs = 5'd2;
        check("jr_over_jump", RED_JR);
        tick();

        idle();
        bus.id_branch = 1'b1; bus.id_eq = 1'b0; bus.id_rs = 5'd6; bus.id_rt = 5'd7;
        check("beq_not_taken", NORMAL);
        tick();

        // Jump while imem not ready: held three cycles, then issued.
        idle();
        bus.id_jump = 1'b1; bus.imem_ready = 1'b0;
        check("jpend_h0", HOLD);
        tick();
        bus.id_jump = 1'b0; bus.id_jr = 1'b1; bus.id_rs = 5'd3;
        check("jpend_h1", HOLD);
        tick();
        check("jpend_h2", HOLD);
        tick();
        bus.imem_ready = 1'b1;
        check("jpend_issue", RED_J);
        tick();
        idle();
        check("jpend_post", NORMAL);
        tick();

        // Reset during a pending redirect discards it.
        bus.id_jump = 1'b1; bus.imem_ready = 1'b0;
        check("rpend_h0", HOLD);
        tick();
        bus.id_jump = 1'b0;
        rst = 1'b1;
        check("rpend_rst", HOLD);
        tick();
        rst = 1'b0;
        idle();
        check("rpend_after", NORMAL);
        tick();

        // Counters: reset, then two 2-stall beq sequences back to back.
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
        beq_load_seq("perf_a");
        beq_load_seq("perf_b");
        idle();
        @(negedge clk);
`ifdef PC_CTRL_PERF_EN
        check_cnt("perf_stalls", bus.perf_stalls, CW'(4));
        check_cnt("perf_flushes", bus.perf_flushes, CW'(2));
`else
        check_cnt("perf_stalls_off", bus.perf_stalls, '0);
        check_cnt("perf_flushes_off", bus.perf_flushes, '0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
